// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core control logic.
//   hcu_state_t            : hazard controller FSM encoding
//   REG_ZERO               : architectural register $zero, never a real dependency
//   DEFAULT_TIMEOUT_CYCLES : default memory-wait supervision limit
package cpu_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hcu_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
//   clk    : rising-edge clock
//   arst_n : asynchronous active-low reset, clears the count
//   inc    : count one event this cycle
//   value  : current count, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller for the 5-stage MIPS core. Resolves hazards
// that forwarding cannot: load-use stalls (one ID/EX bubble), taken-branch
// flushes (IF/ID and ID/EX), and whole-pipeline freezes while a data-memory
// access is outstanding. Also supervises the memory wait and keeps
// saturating performance counters.
//   clk, arst_n           : clock, asynchronous active-low reset
//   IF_IDregisterRs/Rt    : source registers of the ID instruction
//   IF_IDusesRt           : ID instruction reads rt
//   ID_EXmemRead/RegRt    : load in EX and its destination
//   EX_MEMbranchTaken     : branch in MEM resolved taken
//   EX_MEMmemAccess       : MEM instruction accesses data memory
//   dmem_ready            : data memory completes this cycle
//   pc_write .. mem_wb_bubble : pipeline register enables / flushes
//   mem_timeout           : sticky, memory wait reached TIMEOUT_CYCLES
//   load_use_cnt, flush_cnt, mem_wait_cnt : saturating event counters
module hazard_control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       IF_IDregisterRs,
  input  logic [4:0]       IF_IDregisterRt,
  input  logic             IF_IDusesRt,
  input  logic             ID_EXmemRead,
  input  logic [4:0]       ID_EXregisterRt,
  input  logic             EX_MEMbranchTaken,
  input  logic             EX_MEMmemAccess,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);

  hcu_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          raw_freeze, raw_flush, raw_load_use;
  logic          ev_freeze, ev_flush, ev_load_use;
  logic          rt_hit_rs, rt_hit_rt;

  // Raw hazard conditions
  always_comb begin
    rt_hit_rs    = (ID_EXregisterRt == IF_IDregisterRs);
    rt_hit_rt    = IF_IDusesRt && (ID_EXregisterRt == IF_IDregisterRt);
    raw_freeze   = EX_MEMmemAccess && !dmem_ready;
    raw_flush    = EX_MEMbranchTaken;
    raw_load_use = ID_EXmemRead && (ID_EXregisterRt != REG_ZERO)
                   && (rt_hit_rs || rt_hit_rt);
  end

  // Prioritised events: exactly one (or none) applies per cycle. A
  // suppressed branch/load-use stays on the frozen pipeline inputs and is
  // taken up again on the first unfrozen cycle.
  always_comb begin
    ev_freeze   = raw_freeze;
    ev_flush    = !raw_freeze && raw_flush;
    ev_load_use = !raw_freeze && !raw_flush && raw_load_use;
  end

  // Pipeline register controls. Held at their idle values while reset is
  // asserted so the pipeline sees no spurious freeze from live inputs.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    if (arst_n) begin
      if (ev_freeze) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_bubble = 1'b1;
      end else if (ev_flush) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (ev_load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // FSM next state and wait timer. The ready cycle itself is unfrozen, so
  // MEM_WAIT returns to RUN as soon as freeze drops.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      RUN: begin
        timer_d = '0;
        if (ev_freeze) begin
          state_d = MEM_WAIT;
          timer_d = TW'(1);
        end
      end
      MEM_WAIT: begin
        if (ev_freeze) begin
          if (timer_q != TIMER_MAX) begin
            timer_d = timer_q + TW'(1);
          end
        end else begin
          state_d = RUN;
          timer_d = '0;
        end
      end
      default: begin
        state_d = RUN;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= RUN;
      timer_q     <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (timer_d == TIMER_MAX) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_load_use_cnt (
    .clk   (clk),
    .arst_n(arst_n),
    .inc   (ev_load_use),
    .value (load_use_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .arst_n(arst_n),
    .inc   (ev_flush),
    .value (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
    .clk   (clk),
    .arst_n(arst_n),
    .inc   (ev_freeze),
    .value (mem_wait_cnt)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed testbench for hazard_control_unit.
module tb_hazard_control_unit;
  import cpu_pkg::*;

  localparam int unsigned CW = 4;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
  //  ex_mem_write, mem_wb_bubble}
  localparam logic [6:0] C_NORMAL  = 7'b1101010;
  localparam logic [6:0] C_FREEZE  = 7'b0000001;
  localparam logic [6:0] C_FLUSH   = 7'b1111110;
  localparam logic [6:0] C_LOADUSE = 7'b0001110;

  logic          clk = 1'b0;
  logic          arst_n;
  logic [4:0]    IF_IDregisterRs, IF_IDregisterRt, ID_EXregisterRt;
  logic          IF_IDusesRt, ID_EXmemRead, EX_MEMbranchTaken;
  logic          EX_MEMmemAccess, dmem_ready;
  logic          pc_write, if_id_write, if_id_flush, id_ex_write;
  logic          id_ex_flush, ex_mem_write, mem_wb_bubble, mem_timeout;
  logic [CW-1:0] load_use_cnt, flush_cnt, mem_wait_cnt;
  logic [6:0]    ctrl;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (CW)
  ) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .IF_IDregisterRs  (IF_IDregisterRs),
    .IF_IDregisterRt  (IF_IDregisterRt),
    .IF_IDusesRt      (IF_IDusesRt),
    .ID_EXmemRead     (ID_EXmemRead),
    .ID_EXregisterRt  (ID_EXregisterRt),
    .EX_MEMbranchTaken(EX_MEMbranchTaken),
    .EX_MEMmemAccess  (EX_MEMmemAccess),
    .dmem_ready       (dmem_ready),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .if_id_flush      (if_id_flush),
    .id_ex_write      (id_ex_write),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_write     (ex_mem_write),
    .mem_wb_bubble    (mem_wb_bubble),
    .mem_timeout      (mem_timeout),
    .load_use_cnt     (load_use_cnt),
    .flush_cnt        (flush_cnt),
    .mem_wait_cnt     (mem_wait_cnt)
  );

  assign ctrl = {pc_write, if_id_write, if_id_flush, id_ex_write,
                 id_ex_flush, ex_mem_write, mem_wb_bubble};

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    IF_IDregisterRs   = 5'd0;
    IF_IDregisterRt   = 5'd0;
    IF_IDusesRt       = 1'b0;
    ID_EXmemRead      = 1'b0;
    ID_EXregisterRt   = 5'd0;
    EX_MEMbranchTaken = 1'b0;
    EX_MEMmemAccess   = 1'b0;
    dmem_ready        = 1'b1;
  endtask

  task automatic set_load(input logic [4:0] ld_rt, input logic [4:0] rs,
                          input logic [4:0] rt, input logic uses_rt);
    ID_EXmemRead    = 1'b1;
    ID_EXregisterRt = ld_rt;
    IF_IDregisterRs = rs;
    IF_IDregisterRt = rt;
    IF_IDusesRt     = uses_rt;
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    arst_n = 1'b0;
    #2;
    check_eq("reset_ctrl", 32'(ctrl), 32'(C_NORMAL));
    check_eq("reset_cnt", 32'({load_use_cnt, flush_cnt, mem_wait_cnt}), 32'd0);
    check_eq("reset_timeout", 32'(mem_timeout), 32'd0);
    #1 arst_n = 1'b1;
    tick();

    // Load-use on rs: one bubble
    set_load(5'd5, 5'd5, 5'd0, 1'b0);
    #1 check_eq("lu_rs_ctrl", 32'(ctrl), 32'(C_LOADUSE));
    tick();
    idle_inputs();
    #1 check_eq("lu_rs_after", 32'(ctrl), 32'(C_NORMAL));
    check_eq("lu_rs_cnt", 32'(load_use_cnt), 32'd1);

    // $zero destination never stalls
    set_load(5'd0, 5'd0, 5'd0, 1'b1);
    #1 check_eq("lu_zero", 32'(ctrl), 32'(C_NORMAL));
    tick();
    // rt match but rt not used
    set_load(5'd7, 5'd3, 5'd7, 1'b0);
    #1 check_eq("lu_rt_unused", 32'(ctrl), 32'(C_NORMAL));
    tick();
    check_eq("lu_no_cnt", 32'(load_use_cnt), 32'd1);
    // rt match with rt used does stall (combinational only)
    IF_IDusesRt = 1'b1;
    #1 check_eq("lu_rt_used", 32'(ctrl), 32'(C_LOADUSE));
    idle_inputs();
    #1;

    // Memory wait: 3 frozen cycles, then ready
    EX_MEMmemAccess = 1'b1;
    dmem_ready      = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      #1 check_eq($sformatf("freeze_%0d", i), 32'(ctrl), 32'(C_FREEZE));
      tick();
    end
    check_eq("wait_state", 32'(dut.state_q), 32'(MEM_WAIT));
    dmem_ready = 1'b1;
    #1 check_eq("ready_ctrl", 32'(ctrl), 32'(C_NORMAL));
    tick();
    check_eq("wait_cnt", 32'(mem_wait_cnt), 32'd3);
    check_eq("back_run", 32'(dut.state_q), 32'(RUN));
    check_eq("no_timeout", 32'(mem_timeout), 32'd0);
    idle_inputs();
    #1;

    // Priority: freeze beats branch and load-use; then branch beats load-use
    EX_MEMmemAccess   = 1'b1;
    dmem_ready        = 1'b0;
    EX_MEMbranchTaken = 1'b1;
    set_load(5'd9, 5'd9, 5'd0, 1'b0);
    #1 check_eq("prio_freeze", 32'(ctrl), 32'(C_FREEZE));
    tick();
    dmem_ready = 1'b1;
    #1 check_eq("prio_flush", 32'(ctrl), 32'(C_FLUSH));
    tick();
    idle_inputs();
    #1;
    check_eq("prio_flush_cnt", 32'(flush_cnt), 32'd1);
    check_eq("prio_lu_cnt", 32'(load_use_cnt), 32'd1);
    check_eq("prio_wait_cnt", 32'(mem_wait_cnt), 32'd4);

    // Timeout after 4 wait cycles, sticky past the ready cycle
    EX_MEMmemAccess = 1'b1;
    dmem_ready      = 1'b0;
    for (int unsigned i = 1; i <= 6; i++) begin
      tick();
      if (i == 3) check_eq("timeout_3", 32'(mem_timeout), 32'd0);
      if (i == 4) check_eq("timeout_4", 32'(mem_timeout), 32'd1);
    end
    #1 check_eq("timeout_freeze", 32'(ctrl), 32'(C_FREEZE));
    dmem_ready = 1'b1;
    tick();
    idle_inputs();
    #1;
    check_eq("timeout_sticky", 32'(mem_timeout), 32'd1);
    check_eq("timeout_ctrl", 32'(ctrl), 32'(C_NORMAL));
    check_eq("timeout_wait_cnt", 32'(mem_wait_cnt), 32'd10);

    // Counter saturation: 16 more load-use cycles from 1 -> stays at 15
    set_load(5'd12, 5'd0, 5'd12, 1'b1);
    for (int unsigned i = 0; i < 16; i++) tick();
    idle_inputs();
    #1;
    check_eq("lu_saturate", 32'(load_use_cnt), 32'd15);
    check_eq("flush_unchanged", 32'(flush_cnt), 32'd1);

    // Async reset mid-wait
    EX_MEMmemAccess = 1'b1;
    dmem_ready      = 1'b0;
    tick();
    tick();
    check_eq("pre_rst_state", 32'(dut.state_q), 32'(MEM_WAIT));
    #2 arst_n = 1'b0;
    #1;
    check_eq("rst_ctrl", 32'(ctrl), 32'(C_NORMAL));
    check_eq("rst_cnt", 32'({load_use_cnt, flush_cnt, mem_wait_cnt}), 32'd0);
    check_eq("rst_timeout", 32'(mem_timeout), 32'd0);
    check_eq("rst_state", 32'(dut.state_q), 32'(RUN));
    idle_inputs();
    #1 arst_n = 1'b1;
    tick();
    check_eq("post_rst_ctrl", 32'(ctrl), 32'(C_NORMAL));
    check_eq("post_rst_cnt", 32'(mem_wait_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
